sys_array_loader: RTL and testbench
===================================

Name: sys_array_loader

Overview:
- Upstream feed stage for sys_array_fetcher.
- Accepts a serial valid/ready stream of matrix elements and assembles the full A matrix and B matrix in local registers.
- Presents them as parallel matrix buses, pulses load_params and then start_comp, and waits for the fetcher's completion before accepting the next job.
- Sits between the host/DMA stream and the fetcher's input_data_a / input_data_b / load_params / start_comp / ready pins.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- ARRAY_W, 4, matrix rows (i dimension).
- ARRAY_L, 4, matrix columns (j dimension).
- DONE_TIMEOUT, 64, maximum cycles in WAIT before forced completion; must be ≥ 1.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  stream element valid.
- s_ready  out  1  loader can accept an element.
- s_data  in  DATA_WIDTH  stream element.
- s_last  in  1  marks the final element of a job.
- data_a  out  [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  assembled A, to input_data_a.
- data_b  out  [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  assembled B, to input_data_b.
- load_params  out  1  one-cycle pulse, to fetcher load_params.
- start_comp  out  1  one-cycle pulse, to fetcher start_comp.
- comp_done  in  1  fetcher ready (level, may be sticky).
- job_done  out  1  one-cycle pulse when a job completes.
- busy  out  1  high in any state other than RECV_A with zero elements received.
- err_framing  out  1  one-cycle pulse on a framing error.
- err_timeout  out  1  one-cycle pulse when WAIT ends by timeout.

Behaviour:
- Reset values:
  - State RECV_A, element counters 0.
  - data_a and data_b all zero.
  - s_ready 1.
  - load_params, start_comp, job_done, busy, err_framing, err_timeout all 0.
  - Edge register for comp_done cleared to 0.
- Stream order: all of A row-major (i outer, j inner), then all of B row-major, giving 2·W·L elements per job.
- An element is accepted on a cycle with s_valid && s_ready.
- Element e of A is written to data_a[e / L][e % L]; element e of B is written to data_b[e / L][e % L], both at the accepting edge.
- Counters are row/column pairs that wrap at L and W. They must not use division.
- State RECV_A:
  - s_ready = 1.
  - After the W·L-th accepted element → RECV_B.
- State RECV_B:
  - s_ready = 1.
  - After the W·L-th accepted element → LOAD.
- State LOAD:
  - s_ready = 0; load_params = 1 for exactly this cycle.
  - → START.
- State START:
  - start_comp = 1 for exactly this cycle.
  - Capture comp_done into the edge register; clear the timeout counter.
  - → WAIT.
- State WAIT:
  - s_ready = 0.
  - Exit on the rising edge of comp_done (current 1, registered 0), or when the timeout counter reaches DONE_TIMEOUT-1.
  - The timeout path is required because the fetcher's ready is sticky after the first job.
  - On exit: pulse job_done, pulse err_timeout if the exit was by timeout, reset the counters, → RECV_A.
- If a rising edge and the timeout occur in the same cycle, the edge wins: err_timeout = 0.
- data_a and data_b are held stable from LOAD through WAIT. They change only when elements are accepted.
- Framing rules:
  - s_last accepted on any element other than the last → err_framing pulse, job aborted, counters cleared, → RECV_A. Partial contents remain in data_a/data_b and no pulses are issued.
  - Final element accepted with s_last = 0 → err_framing pulse, but the job proceeds normally to LOAD.
- Throughput: one element per cycle. Job overhead is 2 cycles (LOAD, START) plus the WAIT time, plus 1 cycle back to RECV_A.
- Reset asserted mid-job: everything returns to reset values on the next edge. No pulse is emitted on that edge.

Optional Feature:
- Macro: SYS_ARRAY_LOADER_WEIGHT_REUSE_EN.
- When defined:
  - Adds input port reuse_b (1 bit), sampled on the first accepted element of a job, or with s_valid in RECV_A at count 0.
  - If reuse_b = 1, the job consists of W·L A-elements only. s_last is expected on the last A element, RECV_B and LOAD are skipped (RECV_A → START), and data_b is kept unchanged.
  - A reuse_b = 1 job immediately after reset uses zero weights.
- When undefined: no port; every job streams both A and B.

Decomposition:
- Package sys_array_pkg holds:
  - State enum loader_state_t {RECV_A, RECV_B, LOAD, START, WAIT}.
  - Localparam ELEMS_PER_MAT = ARRAY_W*ARRAY_L.
  - Counter width function clog2-based.
- One natural sub-module: sys_array_matrix_reg, a W×L element register bank with write-enable and row/column write address, instantiated twice (A, B).

Test Plan:
- W=L=2, DW=8: stream 1,2,3,4,5,6,7,8 with s_last on 8 → data_a={{1,2},{3,4}}, data_b={{5,6},{7,8}}; load_params one cycle after element 8 accepted, start_comp the next cycle.
- Same job, then comp_done 0→1 after 10 cycles in WAIT → job_done pulse next edge, err_timeout=0, s_ready=1 the following cycle.
- comp_done held at 1 (sticky) across a second job, DONE_TIMEOUT=8 → WAIT exits after exactly 8 cycles with job_done and err_timeout both pulsed.
- s_last on element 3 → err_framing pulse, no load_params/start_comp, state RECV_A; the next full 8-element job completes normally.
- s_valid toggling every other cycle → all 8 elements captured at the correct indices, no element lost or duplicated; reset asserted during RECV_B → all outputs zero and s_ready=1 after one edge.
- With SYS_ARRAY_LOADER_WEIGHT_REUSE_EN defined: reuse_b=1 job of 4 elements → no load_params pulse, data_b unchanged, start_comp one cycle after the 4th element.

Source files
------------

// File: rtl/sys_array_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_pkg
// Description : Shared types and helpers for the systolic-array loader.
//               Holds the loader state encoding, default matrix geometry
//               and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_array_pkg;

  typedef enum logic [2:0] {
    RECV_A = 3'd0,
    RECV_B = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } loader_state_t;

  localparam int DEFAULT_ARRAY_W = 4;
  localparam int DEFAULT_ARRAY_L = 4;
  localparam int ELEMS_PER_MAT   = DEFAULT_ARRAY_W * DEFAULT_ARRAY_L;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_array_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_loader_if
// Description : Stream input, matrix buses and fetcher handshake of the
//               loader. master = stream source / fetcher side, slave = loader.
//               Adds reuse_b when SYS_ARRAY_LOADER_WEIGHT_REUSE_EN is defined.
// Ports       : s_valid/s_ready/s_data/s_last - element stream
//               data_a/data_b                  - assembled matrices
//               load_params/start_comp/comp_done - fetcher handshake
//               job_done/busy/err_framing/err_timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_array_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] data_a;
  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] data_b;
  logic                  load_params;
  logic                  start_comp;
  logic                  comp_done;
  logic                  job_done;
  logic                  busy;
  logic                  err_framing;
  logic                  err_timeout;
`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
  logic                  reuse_b;
`endif

  modport master (
`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
    output reuse_b,
`endif
    output s_valid, s_data, s_last, comp_done,
    input  s_ready, data_a, data_b, load_params, start_comp,
    input  job_done, busy, err_framing, err_timeout
  );

  modport slave (
`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
    input  reuse_b,
`endif
    input  s_valid, s_data, s_last, comp_done,
    output s_ready, data_a, data_b, load_params, start_comp,
    output job_done, busy, err_framing, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/sys_array_matrix_reg.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_matrix_reg
// Description : ARRAY_W x ARRAY_L element register bank with a single
//               addressed write port; the whole bank is visible in parallel.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               we, wr_row, wr_col  - write enable and element address
//               wr_data             - element to store
//               q                   - full matrix, row-major packed
// Revision    : 1.0 - initial release
// ============================================================================
module sys_array_matrix_reg
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4
) (
  input  wire logic                              clk,
  input  wire logic                              reset,
  input  wire logic                              we,
  input  wire logic [cnt_w(ARRAY_W)-1:0]         wr_row,
  input  wire logic [cnt_w(ARRAY_L)-1:0]         wr_col,
  input  wire logic [DATA_WIDTH-1:0]             wr_data,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] q
);

  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (we) begin
      r_q[wr_row][wr_col] <= wr_data;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/sys_array_loader.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_loader
// Description : Collects a serial stream of A then B elements (row-major),
//               presents both matrices in parallel, pulses load_params and
//               start_comp, then waits for a rising comp_done or a timeout.
//               Optional macro SYS_ARRAY_LOADER_WEIGHT_REUSE_EN adds reuse_b:
//               an A-only job that keeps the current B matrix.
// Ports       : clk, reset - clock, synchronous active-high reset
//               bus        - sys_array_loader_if.slave (stream, matrices,
//                            fetcher handshake and status pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module sys_array_loader
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY_W      = 4,
  parameter int ARRAY_L      = 4,
  parameter int DONE_TIMEOUT = 64
) (
  input  wire logic         clk,
  input  wire logic         reset,
  sys_array_loader_if.slave bus
);

  localparam int c_RW = cnt_w(ARRAY_W);
  localparam int c_CW = cnt_w(ARRAY_L);
  localparam int c_TW = cnt_w(DONE_TIMEOUT);
  localparam logic [c_RW-1:0] c_ROW_MAX = c_RW'(ARRAY_W - 1);
  localparam logic [c_CW-1:0] c_COL_MAX = c_CW'(ARRAY_L - 1);
  localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(DONE_TIMEOUT - 1);

  loader_state_t   r_state;
  logic [c_RW-1:0] r_row;
  logic [c_CW-1:0] r_col;
  logic [c_TW-1:0] r_tmo;
  logic            r_comp_prev;
  logic            r_job_done;
  logic            r_err_framing;
  logic            r_err_timeout;

  logic w_accept;
  logic w_at_start;
  logic w_mat_last;
  logic w_job_last;
  logic w_reuse;
  logic w_rise;
  logic w_tmo;

  assign w_accept   = bus.s_valid && bus.s_ready;
  assign w_at_start = (r_state == RECV_A) && (r_row == '0) && (r_col == '0);
  assign w_mat_last = (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);

`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
  logic r_reuse;
  // On the first element the live pin decides; afterwards the captured value.
  assign w_reuse = w_at_start ? bus.reuse_b : r_reuse;
`else
  assign w_reuse = 1'b0;
`endif

  // The final element of a job is the last of B, or the last of A on a reuse job.
  assign w_job_last = w_mat_last &&
                      ((r_state == RECV_B) || ((r_state == RECV_A) && w_reuse));
  assign w_rise     = bus.comp_done && !r_comp_prev;
  assign w_tmo      = (r_tmo == c_TMO_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RECV_A;
      r_row         <= '0;
      r_col         <= '0;
      r_tmo         <= '0;
      r_comp_prev   <= 1'b0;
      r_job_done    <= 1'b0;
      r_err_framing <= 1'b0;
      r_err_timeout <= 1'b0;
`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
      r_reuse       <= 1'b0;
`endif
    end else begin
      r_job_done    <= 1'b0;
      r_err_framing <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        RECV_A, RECV_B: begin
          if (w_accept) begin
`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
            if (w_at_start) r_reuse <= bus.reuse_b;
`endif
            if (bus.s_last && !w_job_last) begin
              // Early s_last: abandon the job, keep whatever was written.
              r_err_framing <= 1'b1;
              r_row         <= '0;
              r_col         <= '0;
              r_state       <= RECV_A;
            end else begin
              // Missing s_last on the final element is flagged but tolerated.
              if (w_job_last && !bus.s_last) r_err_framing <= 1'b1;
              if (w_mat_last) begin
                r_row <= '0;
                r_col <= '0;
                if (r_state == RECV_B)  r_state <= LOAD;
                else if (w_reuse)       r_state <= START;
                else                    r_state <= RECV_B;
              end else if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        LOAD: begin
          r_state <= START;
        end
        START: begin
          // A sticky comp_done already high here must not count as an edge.
          r_comp_prev <= bus.comp_done;
          r_tmo       <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          r_comp_prev <= bus.comp_done;
          r_tmo       <= r_tmo + 1'b1;
          if (w_rise || w_tmo) begin
            r_job_done    <= 1'b1;
            r_err_timeout <= !w_rise;
            r_row         <= '0;
            r_col         <= '0;
            r_state       <= RECV_A;
          end
        end
        default: begin
          r_state <= RECV_A;
        end
      endcase
    end
  end

  sys_array_matrix_reg #(
    .DATA_WIDTH(DATA_WIDTH), .ARRAY_W(ARRAY_W), .ARRAY_L(ARRAY_L)
  ) u_mat_a (
    .clk(clk), .reset(reset), .we(w_accept && (r_state == RECV_A)),
    .wr_row(r_row), .wr_col(r_col), .wr_data(bus.s_data), .q(bus.data_a)
  );

  sys_array_matrix_reg #(
    .DATA_WIDTH(DATA_WIDTH), .ARRAY_W(ARRAY_W), .ARRAY_L(ARRAY_L)
  ) u_mat_b (
    .clk(clk), .reset(reset), .we(w_accept && (r_state == RECV_B)),
    .wr_row(r_row), .wr_col(r_col), .wr_data(bus.s_data), .q(bus.data_b)
  );

  assign bus.s_ready     = (r_state == RECV_A) || (r_state == RECV_B);
  assign bus.load_params = (r_state == LOAD);
  assign bus.start_comp  = (r_state == START);
  assign bus.busy        = !w_at_start;
  assign bus.job_done    = r_job_done;
  assign bus.err_framing = r_err_framing;
  assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_array_loader
// Description : Self-checking bench for sys_array_loader with a 2x2 array,
//               8-bit elements and an 8-cycle completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_array_loader;

  localparam int c_DW = 8;
  localparam int c_W  = 2;
  localparam int c_L  = 2;
  localparam int c_DT = 8;
  localparam int c_N  = c_W * c_L;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sys_array_loader_if #(.DATA_WIDTH(c_DW), .ARRAY_W(c_W), .ARRAY_L(c_L)) bus ();

  sys_array_loader #(
    .DATA_WIDTH(c_DW), .ARRAY_W(c_W), .ARRAY_L(c_L), .DONE_TIMEOUT(c_DT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference contents: element e of a matrix lives at m_x[e] (row-major).
  logic [7:0] m_a [c_N];
  logic [7:0] m_b [c_N];

  typedef struct {
    logic [7:0] base;
    int         last_at;
    bit         gaps;
    int         k;
    bit         sticky;
    int         exp_m;
    bit         exp_to;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed [0:W-1][0:L-1] puts element 0 in the most significant byte.
  function automatic logic [63:0] pack(input logic [7:0] m [c_N]);
    logic [63:0] v = '0;
    for (int e = 0; e < c_N; e++) v = (v << 8) | 64'(m[e]);
    return v;
  endfunction

  task automatic send(input logic [7:0] base, input int count, input int last_at,
                      input bit gaps, input int job_len, output bit aborted);
    aborted = 1'b0;
    for (int idx = 0; idx < count && !aborted; idx++) begin
      if (gaps) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'hEE;
        tick();
      end
      chk("s_ready_recv", 64'(bus.s_ready), 1);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(base + idx);
      bus.s_last  = (idx == last_at);
      tick();
      if (idx < c_N) m_a[idx] = 8'(base + idx);
      else           m_b[idx - c_N] = 8'(base + idx);
      chk("err_framing", 64'(bus.err_framing), 64'((idx == last_at) != (idx == job_len - 1)));
      if (idx == last_at && idx != job_len - 1) aborted = 1'b1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Entered on the cycle where start_comp should be visible.
  task automatic wait_phase(input int k, input bit sticky, input int exp_m, input bit exp_to);
    chk("start_comp", 64'(bus.start_comp), 1);
    chk("load_params_off", 64'(bus.load_params), 0);
    for (int c = 0; c <= exp_m; c++) begin
      tick();
      chk("job_done_early", 64'(bus.job_done), 0);
      chk("s_ready_wait", 64'(bus.s_ready), 0);
      chk("start_comp_once", 64'(bus.start_comp), 0);
      if (!sticky && c == k) bus.comp_done = 1'b1;
    end
    tick();
    chk("job_done", 64'(bus.job_done), 1);
    chk("err_timeout", 64'(bus.err_timeout), 64'(exp_to));
    chk("s_ready_after", 64'(bus.s_ready), 1);
    chk("busy_after", 64'(bus.busy), 0);
    chk("data_a_hold", 64'(bus.data_a), pack(m_a));
    chk("data_b_hold", 64'(bus.data_b), pack(m_b));
    if (!sticky) bus.comp_done = 1'b0;
    tick();
    chk("job_done_pulse", 64'(bus.job_done), 0);
    chk("err_timeout_pulse", 64'(bus.err_timeout), 0);
  endtask

  task automatic run_job(input vec_t v);
    bit ab;
    if (v.sticky) bus.comp_done = 1'b1;
    send(v.base, 2 * c_N, v.last_at, v.gaps, 2 * c_N, ab);
    chk("data_a", 64'(bus.data_a), pack(m_a));
    chk("data_b", 64'(bus.data_b), pack(m_b));
    if (ab) begin
      chk("busy_abort", 64'(bus.busy), 0);
      chk("s_ready_abort", 64'(bus.s_ready), 1);
      tick();
      chk("no_load_abort", 64'(bus.load_params), 0);
      chk("no_start_abort", 64'(bus.start_comp), 0);
      tick();
      chk("no_start_abort2", 64'(bus.start_comp), 0);
    end else begin
      chk("load_params", 64'(bus.load_params), 1);
      chk("s_ready_load", 64'(bus.s_ready), 0);
      chk("busy_load", 64'(bus.busy), 1);
      tick();
      wait_phase(v.k, v.sticky, v.exp_m, v.exp_to);
    end
    if (v.sticky) bus.comp_done = 1'b0;
  endtask

  initial begin
    vec_t tbl [7];
    vec_t rv;
    bit   ab;

    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.comp_done = 1'b0;
`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
    bus.reuse_b = 1'b0;
`endif
    for (int e = 0; e < c_N; e++) begin m_a[e] = '0; m_b[e] = '0; end
    tick();
    tick();
    reset = 1'b0;

    chk("rst_s_ready", 64'(bus.s_ready), 1);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_load", 64'(bus.load_params), 0);
    chk("rst_start", 64'(bus.start_comp), 0);
    chk("rst_job_done", 64'(bus.job_done), 0);
    chk("rst_err_framing", 64'(bus.err_framing), 0);
    chk("rst_err_timeout", 64'(bus.err_timeout), 0);
    chk("rst_data_a", 64'(bus.data_a), 0);
    chk("rst_data_b", 64'(bus.data_b), 0);

    // base, last_at, gaps, k, sticky, expected WAIT exit cycle, expected timeout
    tbl = '{
      '{8'h01,  7, 1'b0,  3, 1'b0, 3, 1'b0},   // 1..8, comp_done rises in WAIT cycle 3
      '{8'h01,  7, 1'b0,  0, 1'b1, 7, 1'b1},   // sticky comp_done: timeout after 8 cycles
      '{8'h11,  2, 1'b0,  0, 1'b0, 0, 1'b0},   // s_last on element 3: abort
      '{8'h21,  7, 1'b1,  5, 1'b0, 5, 1'b0},   // valid every other cycle
      '{8'h31,  7, 1'b0,  7, 1'b0, 7, 1'b0},   // edge and timeout together: edge wins
      '{8'h41,  7, 1'b0, 20, 1'b0, 7, 1'b1},   // comp_done never rises
      '{8'h51, 99, 1'b1,  1, 1'b0, 1, 1'b0}    // missing s_last: flagged, job proceeds
    };
    for (int i = 0; i < 7; i++) run_job(tbl[i]);

    // Reset while receiving B.
    send(8'h61, c_N + 1, -1, 1'b0, 2 * c_N, ab);
    chk("busy_recv_b", 64'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < c_N; e++) begin m_a[e] = '0; m_b[e] = '0; end
    chk("midrst_data_a", 64'(bus.data_a), 0);
    chk("midrst_data_b", 64'(bus.data_b), 0);
    chk("midrst_s_ready", 64'(bus.s_ready), 1);
    chk("midrst_busy", 64'(bus.busy), 0);
    chk("midrst_pulses", 64'({bus.load_params, bus.start_comp, bus.job_done,
                              bus.err_framing, bus.err_timeout}), 0);

`ifdef SYS_ARRAY_LOADER_WEIGHT_REUSE_EN
    // A-only job straight after reset: B stays all zero, LOAD is skipped.
    bus.reuse_b = 1'b1;
    send(8'h71, c_N, c_N - 1, 1'b0, c_N, ab);
    bus.reuse_b = 1'b0;
    chk("reuse_data_a", 64'(bus.data_a), pack(m_a));
    wait_phase(2, 1'b0, 2, 1'b0);
`endif

    // Random jobs; WAIT exit follows the rule "first rising comp_done,
    // otherwise the last permitted cycle DONE_TIMEOUT-1".
    for (int j = 0; j < 8; j++) begin
      rv.base    = 8'($urandom);
      rv.last_at = 2 * c_N - 1;
      rv.gaps    = 1'($urandom_range(0, 1));
      rv.k       = int'($urandom_range(0, 12));
      rv.sticky  = 1'b0;
      rv.exp_m   = (rv.k < c_DT - 1) ? rv.k : c_DT - 1;
      rv.exp_to  = (rv.k > c_DT - 1);
      run_job(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
